uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Asynchronous serial receiver, the counterpart of the team's UART transmitter. Samples line rx with
//  16x oversampling, rebuilds 8N1 frames (LSB first) and presents each byte on dataout with a one-cycle
//  rx_done strobe. Baud rate is selected at run time by bps_set, same encoding as the transmitter.
//  Sits between the board RX pin and the byte-consuming logic on the 16 MHz system clock.
// PARAMETERS
//  CLK_FREQ    16000000  system clock frequency, Hz
//  OVERSAMPLE  16        sample ticks per bit
//  DATA_BITS   8         payload bits per frame
// PORTS
//  clk        in   1          system clock, rising edge
//  rst_n      in   1          reset, asynchronous, active-low
//  bps_set    in   2          baud select: 00=9600 01=19200 10=38400 11=9600
//  rx         in   1          serial line, idle high, asynchronous to clk
//  dataout    out  DATA_BITS  last good byte, held until the next good frame
//  rx_done    out  1          1-cycle strobe, dataout updated this cycle
//  frame_err  out  1          1-cycle strobe, stop bit sampled low
//  busy       out  1          high from start-bit detect until frame end
//  parity_err out  1          only with UART_RX_PARITY_EN; 1-cycle strobe
// BEHAVIOUR
//  - Reset: dataout=0, rx_done=0, frame_err=0, busy=0, parity_err=0, FSM=IDLE, sync regs=1.
//    Async reset mid-frame aborts the frame and emits no strobe.
//  - rx passes a 2-FF synchroniser before any use (2-cycle latency). Logic uses only the synced value.
//  - Tick divisor = CLK_FREQ/(baud*OVERSAMPLE), integer division: 104/52/26 for 9600/19200/38400.
//    Tick counter is cleared on start-bit detect, so sampling is phase-aligned to the falling edge.
//  - bps_set is latched at start-bit detect. Changes mid-frame have no effect until the next frame.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE:  synced rx=0 -> START, busy=1.
//    START: at tick 7 (mid-bit), rx=0 -> DATA; rx=1 -> glitch, IDLE, busy=0, no strobe.
//    DATA:  sample at mid-bit every 16 ticks and shift in LSB first; after DATA_BITS samples go to
//           PARITY if compiled in, else STOP.
//    STOP:  sample at mid-bit. rx=1 -> dataout<=shift reg, rx_done=1. rx=0 -> frame_err=1, dataout kept.
//           Either way -> IDLE and busy=0 in the same cycle (after half a stop bit), so back-to-back frames work.
//  - rx_done and frame_err are mutually exclusive and never longer than 1 cycle.
//  - A low line held in IDLE after a framing error starts a new frame (break is not special-cased).
// CONFIGURATION
//  UART_RX_PARITY_EN defined: a PARITY state follows DATA and samples one even-parity bit.
//    A mismatch gives parity_err=1 and suppresses rx_done/dataout update, but STOP is still checked.
//    If both errors occur in one frame, frame_err and parity_err pulse together.
//  Not defined: no PARITY state, parity_err tied 0, 8N1 only.
// STRUCTURE
//  Shared package uart_pkg: baud constants (9600/19200/38400), bps_set encodings, OVERSAMPLE,
//    FSM state encoding. The transmitter reuses the same package.
//  Sub-module uart_baud_tick: takes bps_set_latched and clear, gives a 1-cycle tick every divisor clocks.
//    This module holds the synchroniser, FSM, tick/bit counters and shift register.
// TESTING
//  1 38400, rx frame for 8'h93 -> one rx_done, dataout=8'h93, frame_err=0.
//    Strobe within 4 clk of the stop mid-point, busy high ~416*9.5 clk.
//  2 19200, 8'h9F then 8'h01 with no idle gap -> two rx_done, dataout 8'h9F then 8'h01.
//  3 9600, 8'h15 with stop bit forced 0 -> frame_err=1 for 1 cycle, no rx_done, dataout unchanged.
//  4 rx low pulse of 200 clk in IDLE at 9600 -> glitch reject, busy falls by tick 7, no strobes.
//  5 rst_n low mid-DATA, then a clean 8'hA5 frame -> outputs 0 during reset, then only 8'hA5 received.
//  6 bps_set changes 10->00 mid-frame -> frame still decoded at 38400; the next frame uses 9600.
//    With UART_RX_PARITY_EN: 8'h93 sent with a wrong parity bit -> parity_err=1, no rx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: baud rates, bps_set encodings, oversampling and receiver FSM states.
// Used by uart_rx and uart_baud_tick; the transmitter reuses the same package.
package uart_pkg;

    localparam int unsigned UART_CLK_FREQ   = 16000000;
    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    localparam int unsigned BAUD_9600  = 9600;
    localparam int unsigned BAUD_19200 = 19200;
    localparam int unsigned BAUD_38400 = 38400;

    // bps_set encodings; 2'b11 falls back to 9600
    localparam logic [1:0] BPS_9600     = 2'b00;
    localparam logic [1:0] BPS_19200    = 2'b01;
    localparam logic [1:0] BPS_38400    = 2'b10;
    localparam logic [1:0] BPS_9600_ALT = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every CLK_FREQ/(baud*OVERSAMPLE) clocks.
// clear restarts the divider so the tick phase lines up with the start-bit edge.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bps_set_latched,
    input  logic       clear,
    output logic       tick
);

    localparam int unsigned CntW = 16;
    // Terminal counts (divisor - 1), integer division rounds down
    localparam logic [CntW-1:0] Last9600  = CntW'(CLK_FREQ / (BAUD_9600 * OVERSAMPLE) - 1);
    localparam logic [CntW-1:0] Last19200 = CntW'(CLK_FREQ / (BAUD_19200 * OVERSAMPLE) - 1);
    localparam logic [CntW-1:0] Last38400 = CntW'(CLK_FREQ / (BAUD_38400 * OVERSAMPLE) - 1);

    logic [CntW-1:0] div_last;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_last;

    // Select the terminal count for the latched baud rate
    always_comb begin
        case (bps_set_latched)
            BPS_19200: div_last = Last19200;
            BPS_38400: div_last = Last38400;
            default:   div_last = Last9600;
        endcase
    end

    // Divider next state and tick strobe
    always_comb begin
        at_last = (cnt_q >= div_last);
        tick    = at_last && !clear;
        if (clear || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Divider counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, 16x oversampled 8N1 frame decoder, LSB first.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = UART_CLK_FREQ,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           bps_set,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dataout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 parity_err
);

    localparam int unsigned TickW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW  = $clog2(DATA_BITS);
    // Tick index of the bit centre counted from the start edge, and of a full bit after that
    localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_sync_q;
    uart_state_e          state_q, state_d;
    logic [TickW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           bps_lat_q, bps_lat_d;
    logic [DATA_BITS-1:0] dataout_q, dataout_d;
    logic                 rx_done_q, rx_done_d;
    logic                 frame_err_q, frame_err_d;
    logic                 baud_clear;
    logic                 baud_tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk             (clk),
        .rst_n           (rst_n),
        .bps_set_latched (bps_lat_q),
        .clear           (baud_clear),
        .tick            (baud_tick)
    );

    // Two-flop synchroniser for the asynchronous line, idle-high at reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM next state, sampling and strobe generation
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        bps_lat_d   = bps_lat_q;
        dataout_d   = dataout_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
        baud_clear  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (!rx_sync_q) begin
                    state_d    = StStart;
                    baud_clear = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    bps_lat_d  = bps_set;
`ifdef UART_RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            StStart: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TickMid) begin
                        tick_cnt_d = '0;
                        // Line back high at mid-bit: treat as a glitch
                        state_d    = rx_sync_q ? StIdle : StData;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        // Even parity: received bit must equal XOR of the data bits
                        par_bad_d  = rx_sync_q ^ (^shift_q);
                        state_d    = StStop;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (baud_tick) begin
                    if (tick_cnt_q == TickLast) begin
                        tick_cnt_d = '0;
                        // Return to idle at mid-stop so a back-to-back start edge is not missed
                        state_d    = StIdle;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = par_bad_q;
                        if (rx_sync_q && !par_bad_q) begin
`else
                        if (rx_sync_q) begin
`endif
                            dataout_d = shift_q;
                            rx_done_d = 1'b1;
                        end
                        if (!rx_sync_q) begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame state, counters, shift register and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            bps_lat_q   <= BPS_9600;
            dataout_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            bps_lat_q   <= bps_lat_d;
            dataout_q   <= dataout_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity tracking registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign dataout   = dataout_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven on rx with an ideal bit period, the expected
// outcome of each frame is queued at issue time and a monitor pops it when a strobe appears.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] bps_set = 2'b00;
    logic       rx = 1'b1;
    logic [7:0] dataout;
    logic       rx_done, frame_err, busy, parity_err;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bps_set    (bps_set),
        .rx         (rx),
        .dataout    (dataout),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .busy       (busy),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       done;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] last_good = 8'h00;
    int         busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    // Clocks per bit as the receiver sees it: 16 ticks of floor(16 MHz / (baud * 16))
    function automatic int bit_clks(input logic [1:0] b);
        int baud;
        baud = (b == 2'b01) ? 19200 : (b == 2'b10) ? 38400 : 9600;
        return 16 * (16000000 / (baud * 16));
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
    endtask

    // Reference model: outcome of one frame from its byte, stop bit and parity bit correctness
    task automatic expect_frame(input logic [7:0] d, input logic stop_ok, input logic par_ok);
        exp_t e;
        e.ferr = !stop_ok;
`ifdef UART_RX_PARITY_EN
        e.perr = !par_ok;
        e.done = stop_ok && par_ok;
`else
        e.perr = 1'b0;
        e.done = stop_ok;
`endif
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [1:0] b, input logic [7:0] d, input logic stop_ok,
                              input logic par_ok, input logic chg, input logic [1:0] b_mid);
        int n;
        n = bit_clks(b);
        bps_set = b;
        hold(1'b0, n);
        for (int i = 0; i < 8; i++) begin
            if (chg && i == 4) bps_set = b_mid;
            hold(d[i], n);
        end
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ !par_ok, n);
`endif
        if (stop_ok) begin
            hold(1'b1, n);
        end else begin
            // Low past the centre, then high so the trailing low is rejected as a glitch
            hold(1'b0, (n * 3) / 4);
            hold(1'b1, n / 4);
        end
    endtask

    // Monitor: pop and compare whenever any strobe is presented
    always @(negedge clk) begin
        if (!rst_n) begin
            last_good = 8'h00;
        end else begin
            if (busy) busy_cnt++;
            if (rx_done || frame_err || parity_err) begin
                exp_t e;
                check("done/frame_err exclusive", {31'd0, rx_done & frame_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected strobe", {29'd0, rx_done, frame_err, parity_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobes", {29'd0, rx_done, frame_err, parity_err},
                          {29'd0, e.done, e.ferr, e.perr});
                    if (e.done) begin
                        check("dataout", {24'd0, dataout}, {24'd0, e.data});
                        last_good = e.data;
                    end else begin
                        check("dataout held", {24'd0, dataout}, {24'd0, last_good});
                    end
                end
            end
        end
    end

    initial begin
        int         b0;
        logic [7:0] d;
        logic       s_ok, p_ok;
        logic [1:0] b;

        // Reset values
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset dataout", {24'd0, dataout}, 32'd0);
        check("reset strobes", {29'd0, rx_done, frame_err, parity_err}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 20);

        // 1: 38400, 8'h93; busy spans 9.5 bits of 416 clk
        b0 = busy_cnt;
        expect_frame(8'h93, 1'b1, 1'b1);
        send_frame(2'b10, 8'h93, 1'b1, 1'b1, 1'b0, 2'b10);
        check_range("t1 busy cycles", busy_cnt - b0, 3949, 3956);
        hold(1'b1, 2 * bit_clks(2'b10));

        // 2: 19200 back-to-back
        expect_frame(8'h9F, 1'b1, 1'b1);
        expect_frame(8'h01, 1'b1, 1'b1);
        send_frame(2'b01, 8'h9F, 1'b1, 1'b1, 1'b0, 2'b01);
        send_frame(2'b01, 8'h01, 1'b1, 1'b1, 1'b0, 2'b01);
        hold(1'b1, 2 * bit_clks(2'b01));

        // 3: 9600 (alternate encoding) with stop bit low
        expect_frame(8'h15, 1'b0, 1'b1);
        send_frame(2'b11, 8'h15, 1'b0, 1'b1, 1'b0, 2'b11);
        hold(1'b1, 2 * bit_clks(2'b11));
        @(negedge clk);
        check("t3 dataout kept", {24'd0, dataout}, 32'h01);

        // 4: 200-clk low pulse at 9600 is rejected at the start-bit centre
        bps_set = 2'b00;
        b0 = busy_cnt;
        hold(1'b0, 200);
        hold(1'b1, 1200);
        @(negedge clk);
        check("t4 busy idle", {31'd0, busy}, 32'd0);
        check_range("t4 busy cycles", busy_cnt - b0, 825, 840);

        // 5: reset mid-DATA, then a clean frame
        bps_set = 2'b10;
        hold(1'b0, bit_clks(2'b10));
        hold(1'b1, 3 * bit_clks(2'b10));
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5 reset dataout", {24'd0, dataout}, 32'd0);
        check("t5 reset busy", {31'd0, busy}, 32'd0);
        check("t5 reset strobes", {29'd0, rx_done, frame_err, parity_err}, 32'd0);
        rst_n = 1'b1;
        hold(1'b1, 20);
        expect_frame(8'hA5, 1'b1, 1'b1);
        send_frame(2'b10, 8'hA5, 1'b1, 1'b1, 1'b0, 2'b10);
        hold(1'b1, 2 * bit_clks(2'b10));

        // 6: bps_set 10->00 mid-frame; the next frame runs at 9600
        expect_frame(8'h3C, 1'b1, 1'b1);
        send_frame(2'b10, 8'h3C, 1'b1, 1'b1, 1'b1, 2'b00);
        hold(1'b1, 2 * bit_clks(2'b10));
        expect_frame(8'hC6, 1'b1, 1'b1);
        send_frame(2'b00, 8'hC6, 1'b1, 1'b1, 1'b0, 2'b00);
        hold(1'b1, bit_clks(2'b00));

`ifdef UART_RX_PARITY_EN
        // Wrong parity alone, then wrong parity plus bad stop
        expect_frame(8'h93, 1'b1, 1'b0);
        send_frame(2'b10, 8'h93, 1'b1, 1'b0, 1'b0, 2'b10);
        hold(1'b1, 2 * bit_clks(2'b10));
        expect_frame(8'h5A, 1'b0, 1'b0);
        send_frame(2'b10, 8'h5A, 1'b0, 1'b0, 1'b0, 2'b10);
        hold(1'b1, 2 * bit_clks(2'b10));
`endif

        // Randomised frames
        for (int i = 0; i < 4; i++) begin
            d    = 8'($urandom);
            s_ok = ($urandom_range(0, 3) != 0);
            p_ok = ($urandom_range(0, 3) != 0);
            b    = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b10;
            expect_frame(d, s_ok, p_ok);
            send_frame(b, d, s_ok, p_ok, 1'b0, b);
            hold(1'b1, 2 * bit_clks(b));
        end

        hold(1'b1, 100);
        check("all expected strobes seen", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
